decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 62 ++++++
 rtl/imm_gen.sv | 35 +++
 rtl/decode_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
//==============================================================================
// Module      : decode_pkg
// Description : Shared definitions for the decode stage: RV32I opcode
//               constants, instruction format classification, and the bit
//               layout of the packed control word handed to execute.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package decode_pkg;

    // Width of the packed control word:
    // {opcode[6:0], funct3[2:0], funct7[5], reg_write, mem_read, mem_write}
    localparam int CTRL_W = 14;

    localparam int CTRL_OPC_MSB   = 13;
    localparam int CTRL_OPC_LSB   = 7;
    localparam int CTRL_F3_MSB    = 6;
    localparam int CTRL_F3_LSB    = 4;
    localparam int CTRL_F7B5      = 3;
    localparam int CTRL_REG_WRITE = 2;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 0;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Instruction encoding format; FMT_NONE covers every unrecognised opcode.
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    function automatic fmt_e opcode_fmt(input logic [6:0] opcode);
        fmt_e fmt;
        case (opcode)
            OPC_OP:                        fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
            OPC_STORE:                     fmt = FMT_S;
            OPC_BRANCH:                    fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:            fmt = FMT_U;
            OPC_JAL:                       fmt = FMT_J;
            default:                       fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen.sv
//==============================================================================
// Module      : imm_gen
// Description : Combinational RV32I immediate generator. Produces the
//               sign-extended I/S/B/U/J immediate selected by the opcode;
//               any other opcode yields zero.
// Ports       : instr_i - 32-bit instruction word
//               imm_o   - 32-bit sign-extended immediate
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (opcode_fmt(instr_i[6:0]))
            FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: imm_o = {instr_i[31:12], 12'b0};
            FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
//==============================================================================
// Module      : decode_stage
// Description : RV32I decode pipeline stage. Decodes the fetched instruction,
//               reads operands (with write-back bypass), detects load-use
//               hazards, and presents the result through a one-entry output
//               register with valid/ready handshaking.
// Ports       : clk, reset (sync, active-low)
//               in_valid/in_ready/in_instr/in_pc   - fetch handshake
//               rf_raddr1/2, rf_rdata1/2           - register-file read
//               wb_we/wb_rd/wb_data                - write-back bypass
//               ex_load/ex_rd                      - load in execute
//               flush                              - kill decode output
//               out_valid/out_ready/out_*          - execute handshake
//               stall_count                        - saturating stall counter
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,

    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,

    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,

    input  logic              ex_load,
    input  logic [4:0]        ex_rd,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [XLEN-1:0]   out_imm,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    //--------------------------------------------------------------------------
    // Field extraction and classification
    //--------------------------------------------------------------------------
    logic [6:0] opcode_w;
    logic [4:0] rd_w;
    logic [4:0] rs1_w;
    logic [4:0] rs2_w;
    logic [2:0] funct3_w;
    fmt_e       fmt_w;

    assign opcode_w = in_instr[6:0];
    assign rd_w     = in_instr[11:7];
    assign funct3_w = in_instr[14:12];
    assign rs1_w    = in_instr[19:15];
    assign rs2_w    = in_instr[24:20];
    assign fmt_w    = opcode_fmt(opcode_w);

    assign rf_raddr1 = rs1_w;
    assign rf_raddr2 = rs2_w;

    // Unknown opcodes read no registers, so they can never cause a stall.
    logic rs1_used_w;
    logic rs2_used_w;

    assign rs1_used_w = (fmt_w == FMT_R) || (fmt_w == FMT_I) ||
                        (fmt_w == FMT_S) || (fmt_w == FMT_B);
    assign rs2_used_w = (fmt_w == FMT_R) || (fmt_w == FMT_S) ||
                        (fmt_w == FMT_B);

    //--------------------------------------------------------------------------
    // Control word
    //--------------------------------------------------------------------------
    logic              reg_write_w;
    logic              mem_read_w;
    logic              mem_write_w;
    logic [CTRL_W-1:0] ctrl_w;

    // Every format that carries an rd writes it, except a write to x0.
    assign reg_write_w = ((fmt_w == FMT_R) || (fmt_w == FMT_I) ||
                          (fmt_w == FMT_U) || (fmt_w == FMT_J)) &&
                         (rd_w != 5'd0);
    assign mem_read_w  = (opcode_w == OPC_LOAD);
    assign mem_write_w = (opcode_w == OPC_STORE);

    always_comb begin
        ctrl_w                               = '0;
        ctrl_w[CTRL_OPC_MSB:CTRL_OPC_LSB]    = opcode_w;
        ctrl_w[CTRL_F3_MSB:CTRL_F3_LSB]      = funct3_w;
        ctrl_w[CTRL_F7B5]                    = in_instr[30];
        ctrl_w[CTRL_REG_WRITE]               = reg_write_w;
        ctrl_w[CTRL_MEM_READ]                = mem_read_w;
        ctrl_w[CTRL_MEM_WRITE]               = mem_write_w;
    end

    //--------------------------------------------------------------------------
    // Operand read with same-cycle write-back bypass
    //--------------------------------------------------------------------------
    function automatic logic [XLEN-1:0] read_operand(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rdata,
        input logic            we,
        input logic [4:0]      wrd,
        input logic [XLEN-1:0] wdata
    );
        if (addr == 5'd0) begin
            return '0;
        end else if (we && (wrd == addr)) begin
            return wdata;
        end else begin
            return rdata;
        end
    endfunction

    logic [XLEN-1:0] op1_w;
    logic [XLEN-1:0] op2_w;

    assign op1_w = read_operand(rs1_w, rf_rdata1, wb_we, wb_rd, wb_data);
    assign op2_w = read_operand(rs2_w, rf_rdata2, wb_we, wb_rd, wb_data);

    //--------------------------------------------------------------------------
    // Immediate
    //--------------------------------------------------------------------------
    logic [31:0] imm_w;

    imm_gen u_imm_gen (
        .instr_i (in_instr),
        .imm_o   (imm_w)
    );

    //--------------------------------------------------------------------------
    // Load-use hazard and handshake
    //--------------------------------------------------------------------------
    logic stall_w;
    logic accept_w;
    logic out_valid_q;

    assign stall_w = ex_load && (ex_rd != 5'd0) &&
                     ((rs1_used_w && (ex_rd == rs1_w)) ||
                      (rs2_used_w && (ex_rd == rs2_w)));

    // Gating with reset keeps fetch from being consumed while the stage is
    // held in reset, since the register below would discard it anyway.
    assign in_ready = reset && !stall_w && !flush && (!out_valid_q || out_ready);
    assign accept_w = in_valid && in_ready;

    //--------------------------------------------------------------------------
    // Output register
    //--------------------------------------------------------------------------
    logic              out_valid_d;
    logic [XLEN-1:0]   out_pc_d,   out_pc_q;
    logic [XLEN-1:0]   out_op1_d,  out_op1_q;
    logic [XLEN-1:0]   out_op2_d,  out_op2_q;
    logic [XLEN-1:0]   out_imm_d,  out_imm_q;
    logic [4:0]        out_rd_d,   out_rd_q;
    logic [CTRL_W-1:0] out_ctrl_d, out_ctrl_q;
    logic [CNT_W-1:0]  stall_count_d, stall_count_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_op1_d   = out_op1_q;
        out_op2_d   = out_op2_q;
        out_imm_d   = out_imm_q;
        out_rd_d    = out_rd_q;
        out_ctrl_d  = out_ctrl_q;

        // in_ready already excludes flush, so flush and accept never overlap;
        // the explicit ordering documents that flush wins.
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_w) begin
            out_valid_d = 1'b1;
            out_pc_d    = in_pc;
            out_op1_d   = op1_w;
            out_op2_d   = op2_w;
            out_imm_d   = imm_w;
            out_rd_d    = rd_w;
            out_ctrl_d  = ctrl_w;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (in_valid && stall_w && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_op1_q     <= '0;
            out_op2_q     <= '0;
            out_imm_q     <= '0;
            out_rd_q      <= '0;
            out_ctrl_q    <= '0;
            stall_count_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_op1_q     <= out_op1_d;
            out_op2_q     <= out_op2_d;
            out_imm_q     <= out_imm_d;
            out_rd_q      <= out_rd_d;
            out_ctrl_q    <= out_ctrl_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_op1     = out_op1_q;
    assign out_op2     = out_op2_q;
    assign out_imm     = out_imm_q;
    assign out_rd      = out_rd_q;
    assign out_ctrl    = out_ctrl_q;
    assign stall_count = stall_count_q;

endmodule

`default_nettype wire
